// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM/WB stage and its access watchdog.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int DW_DEFAULT      = 32;

  // Counter width able to hold 0..timeout-1; never narrower than one bit.
  function automatic int wd_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Saturating wait counter for an outstanding memory access.
// expired is combinational: high while run is high and the count sits at TIMEOUT-1.
module mem_watchdog
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int            CW   = wd_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Holds at LAST rather than wrapping so a late expiry can never be missed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 1-cycle pass-through for ALU ops, one blocking request per load/store.
// Holds EX/MEM via stall_M until mem_ack or watchdog expiry; a timed-out access retires with no register write.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int DW      = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_M,
  input  logic          pcload_M,
  input  logic          regw_M,
  input  logic          memw_M,
  input  logic          regmem_M,
  input  logic [3:0]    regScr_M,
  input  logic [DW-1:0] ALUrslt_M,
  input  logic [DW-1:0] address_M,
  output logic          stall_M,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          valid_W,
  output logic          pcload_W,
  output logic          regw_W,
  output logic [3:0]    regScr_W,
  output logic [DW-1:0] result_W,
  output logic          bus_err
);

  state_t state;
  logic   mem_op;
  logic   expired;
  logic   wd_clear;
  logic   wd_run;

  assign mem_op   = valid_M & (memw_M | regmem_M);
  assign wd_clear = (state == IDLE) & mem_op;
  assign wd_run   = (state == BUSY) & ~mem_ack;

  // Stall also drops on expiry: the aborted instruction retires on that edge
  // and must leave EX/MEM, otherwise IDLE would reissue it.
  assign stall_M = (state == IDLE) ? mem_op : (~mem_ack & ~expired);

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid_W   <= 1'b0;
      pcload_W  <= 1'b0;
      regw_W    <= 1'b0;
      regScr_W  <= '0;
      result_W  <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= memw_M;
            mem_addr  <= address_M;
            mem_wdata <= ALUrslt_M;
            valid_W   <= 1'b0;
            pcload_W  <= 1'b0;
            regw_W    <= 1'b0;
            state     <= BUSY;
          end else begin
            valid_W  <= valid_M;
            pcload_W <= valid_M & pcload_M;
            regw_W   <= valid_M & regw_M;
            regScr_W <= regScr_M;
            result_W <= ALUrslt_M;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            // A store (including memw_M with regmem_M) never writes the register file.
            mem_req  <= 1'b0;
            valid_W  <= valid_M;
            pcload_W <= valid_M & pcload_M;
            regw_W   <= valid_M & regw_M & ~memw_M;
            regScr_W <= regScr_M;
            result_W <= memw_M ? ALUrslt_M : mem_rdata;
            state    <= IDLE;
          end else if (expired) begin
            mem_req  <= 1'b0;
            bus_err  <= 1'b1;
            valid_W  <= valid_M;
            pcload_W <= valid_M & pcload_M;
            regw_W   <= 1'b0;
            regScr_W <= regScr_M;
            result_W <= '0;
            state    <= IDLE;
          end else begin
            valid_W  <= 1'b0;
            pcload_W <= 1'b0;
            regw_W   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a transaction-level reference model.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_M, pcload_M, regw_M, memw_M, regmem_M;
  logic [3:0]    regScr_M;
  logic [DW-1:0] ALUrslt_M, address_M;
  logic          stall_M, mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          valid_W, pcload_W, regw_W;
  logic [3:0]    regScr_W;
  logic [DW-1:0] result_W;
  logic          bus_err;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic          v, pc, rw, mw, rm;
    logic [3:0]    rs;
    logic [DW-1:0] alu, addr;
    int            lat;
  } ins_t;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TO), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .valid_M(valid_M), .pcload_M(pcload_M), .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .address_M(address_M),
    .stall_M(stall_M), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_W(valid_W), .pcload_W(pcload_W), .regw_W(regw_W), .regScr_W(regScr_W), .result_W(result_W),
    .bus_err(bus_err)
  );

  task automatic sync(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  task automatic drive(input logic v, pc, rw, mw, rm, input logic [3:0] rs,
                       input logic [DW-1:0] alu, addr);
    valid_M = v; pcload_M = pc; regw_M = rw; memw_M = mw; regmem_M = rm;
    regScr_M = rs; ALUrslt_M = alu; address_M = addr;
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 4'd0, '0, '0); endtask

  task automatic test_reset();
    idle(); mem_ack = 0; mem_rdata = '0; rst = 0;
    repeat (2) mid();
    n_chk++; if (mem_req   !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req);     else n_pass++;
    n_chk++; if (mem_we    !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we);       else n_pass++;
    n_chk++; if (mem_addr  !== '0)   $display("FAIL reset_mem_addr got %h want 0", mem_addr);   else n_pass++;
    n_chk++; if (mem_wdata !== '0)   $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
    n_chk++; if (valid_W   !== 1'b0) $display("FAIL reset_valid_W got %b want 0", valid_W);     else n_pass++;
    n_chk++; if (pcload_W  !== 1'b0) $display("FAIL reset_pcload_W got %b want 0", pcload_W);   else n_pass++;
    n_chk++; if (regw_W    !== 1'b0) $display("FAIL reset_regw_W got %b want 0", regw_W);       else n_pass++;
    n_chk++; if (regScr_W  !== 4'd0) $display("FAIL reset_regScr_W got %h want 0", regScr_W);   else n_pass++;
    n_chk++; if (result_W  !== '0)   $display("FAIL reset_result_W got %h want 0", result_W);   else n_pass++;
    n_chk++; if (bus_err   !== 1'b0) $display("FAIL reset_bus_err got %b want 0", bus_err);     else n_pass++;
    n_chk++; if (stall_M   !== 1'b0) $display("FAIL reset_stall_M got %b want 0", stall_M);     else n_pass++;
    rst = 1;
  endtask

  task automatic test_alu();
    sync(); drive(1, 0, 1, 0, 0, 4'b0011, 32'h0000FFFF, 32'h0);
    mid();
    n_chk++; if (stall_M !== 1'b0) $display("FAIL alu_stall got %b want 0", stall_M); else n_pass++;
    sync(); idle();
    mid();
    n_chk++; if (valid_W  !== 1'b1)         $display("FAIL alu_valid_W got %b want 1", valid_W);           else n_pass++;
    n_chk++; if (regScr_W !== 4'd3)         $display("FAIL alu_regScr_W got %h want 3", regScr_W);         else n_pass++;
    n_chk++; if (result_W !== 32'h0000FFFF) $display("FAIL alu_result_W got %h want 0000ffff", result_W); else n_pass++;
    n_chk++; if (regw_W   !== 1'b1)         $display("FAIL alu_regw_W got %b want 1", regw_W);             else n_pass++;
    n_chk++; if (stall_M  !== 1'b0)         $display("FAIL alu_stall2 got %b want 0", stall_M);            else n_pass++;
  endtask

  task automatic test_load();
    int stalls = 0;
    sync(); drive(1, 0, 1, 0, 1, 4'd5, 32'h0BAD0000, 32'h00010004); mem_ack = 0;
    mid(); if (stall_M) stalls++;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL load_req_issue got %b want 0", mem_req); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      sync(); mem_ack = (k == 4); mem_rdata = (k == 4) ? 32'hDEADBEEF : $urandom();
      mid(); if (stall_M) stalls++;
      n_chk++; if (mem_req  !== 1'b1)         $display("FAIL load_req k=%0d got %b want 1", k, mem_req);         else n_pass++;
      n_chk++; if (mem_addr !== 32'h00010004) $display("FAIL load_addr k=%0d got %h want 00010004", k, mem_addr); else n_pass++;
      n_chk++; if (valid_W  !== 1'b0)         $display("FAIL load_bubble k=%0d got %b want 0", k, valid_W);      else n_pass++;
    end
    n_chk++; if (mem_we !== 1'b0) $display("FAIL load_we got %b want 0", mem_we); else n_pass++;
    sync(); mem_ack = 0; idle();
    mid();
    n_chk++; if (mem_req  !== 1'b0)         $display("FAIL load_req_drop got %b want 0", mem_req);        else n_pass++;
    n_chk++; if (valid_W  !== 1'b1)         $display("FAIL load_valid_W got %b want 1", valid_W);         else n_pass++;
    n_chk++; if (regw_W   !== 1'b1)         $display("FAIL load_regw_W got %b want 1", regw_W);           else n_pass++;
    n_chk++; if (regScr_W !== 4'd5)         $display("FAIL load_regScr_W got %h want 5", regScr_W);       else n_pass++;
    n_chk++; if (result_W !== 32'hDEADBEEF) $display("FAIL load_result got %h want deadbeef", result_W);  else n_pass++;
    n_chk++; if (stalls   !== 4)            $display("FAIL load_stall_cycles got %0d want 4", stalls);    else n_pass++;
  endtask

  task automatic test_store();
    logic [DW-1:0] a = $urandom();
    sync(); drive(1, 0, 1, 1, 1, 4'd9, 32'h12345678, a); mem_ack = 0;
    mid();
    n_chk++; if (stall_M !== 1'b1) $display("FAIL store_stall got %b want 1", stall_M); else n_pass++;
    sync(); mem_ack = 1; mem_rdata = $urandom();
    mid();
    n_chk++; if (mem_we    !== 1'b1)         $display("FAIL store_we got %b want 1", mem_we);               else n_pass++;
    n_chk++; if (mem_wdata !== 32'h12345678) $display("FAIL store_wdata got %h want 12345678", mem_wdata);  else n_pass++;
    n_chk++; if (mem_addr  !== a)            $display("FAIL store_addr got %h want %h", mem_addr, a);       else n_pass++;
    sync(); mem_ack = 0; idle();
    mid();
    n_chk++; if (valid_W  !== 1'b1)         $display("FAIL store_valid_W got %b want 1", valid_W);         else n_pass++;
    n_chk++; if (regw_W   !== 1'b0)         $display("FAIL store_regw_W got %b want 0", regw_W);           else n_pass++;
    n_chk++; if (result_W !== 32'h12345678) $display("FAIL store_result got %h want 12345678", result_W);  else n_pass++;
  endtask

  task automatic test_ack_at_timeout();
    logic [DW-1:0] rd = $urandom();
    sync(); drive(1, 0, 1, 0, 1, 4'd7, $urandom(), $urandom()); mem_ack = 0;
    for (int k = 1; k <= TO; k++) begin
      sync(); mem_ack = (k == TO); mem_rdata = rd;
      mid();
      n_chk++; if (mem_req !== 1'b1) $display("FAIL acktmo_req k=%0d got %b want 1", k, mem_req); else n_pass++;
    end
    sync(); mem_ack = 0; idle();
    mid();
    n_chk++; if (mem_req  !== 1'b0) $display("FAIL acktmo_req_drop got %b want 0", mem_req);   else n_pass++;
    n_chk++; if (bus_err  !== 1'b0) $display("FAIL acktmo_bus_err got %b want 0", bus_err);    else n_pass++;
    n_chk++; if (regw_W   !== 1'b1) $display("FAIL acktmo_regw_W got %b want 1", regw_W);      else n_pass++;
    n_chk++; if (result_W !== rd)   $display("FAIL acktmo_result got %h want %h", result_W, rd); else n_pass++;
  endtask

  task automatic test_idle_ack();
    sync(); idle(); mem_ack = 1; mem_rdata = $urandom();
    mid();
    n_chk++; if (stall_M !== 1'b0) $display("FAIL idleack_stall got %b want 0", stall_M); else n_pass++;
    sync(); mem_ack = 0;
    mid();
    n_chk++; if (mem_req !== 1'b0) $display("FAIL idleack_req got %b want 0", mem_req);   else n_pass++;
    n_chk++; if (valid_W !== 1'b0) $display("FAIL idleack_valid got %b want 0", valid_W); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] r1 = $urandom(), r2 = $urandom();
    logic [DW-1:0] a1 = $urandom(), a2 = $urandom();
    sync(); drive(1, 0, 1, 0, 1, 4'd1, $urandom(), a1); mem_ack = 0;
    mid();
    n_chk++; if (mem_req !== 1'b0) $display("FAIL b2b_req0 got %b want 0", mem_req); else n_pass++;
    sync(); mem_ack = 1; mem_rdata = r1;
    mid();
    n_chk++; if (mem_req  !== 1'b1) $display("FAIL b2b_req1 got %b want 1", mem_req);           else n_pass++;
    n_chk++; if (mem_addr !== a1)   $display("FAIL b2b_addr1 got %h want %h", mem_addr, a1);    else n_pass++;
    n_chk++; if (stall_M  !== 1'b0) $display("FAIL b2b_stall1 got %b want 0", stall_M);         else n_pass++;
    sync(); drive(1, 0, 1, 0, 1, 4'd2, $urandom(), a2); mem_ack = 0;
    mid();
    n_chk++; if (mem_req  !== 1'b0) $display("FAIL b2b_gap got %b want 0", mem_req);            else n_pass++;
    n_chk++; if (valid_W  !== 1'b1) $display("FAIL b2b_valid1 got %b want 1", valid_W);         else n_pass++;
    n_chk++; if (regScr_W !== 4'd1) $display("FAIL b2b_rs1 got %h want 1", regScr_W);           else n_pass++;
    n_chk++; if (result_W !== r1)   $display("FAIL b2b_res1 got %h want %h", result_W, r1);     else n_pass++;
    sync(); mem_ack = 1; mem_rdata = r2;
    mid();
    n_chk++; if (mem_req  !== 1'b1) $display("FAIL b2b_req2 got %b want 1", mem_req);           else n_pass++;
    n_chk++; if (mem_addr !== a2)   $display("FAIL b2b_addr2 got %h want %h", mem_addr, a2);    else n_pass++;
    sync(); mem_ack = 0; idle();
    mid();
    n_chk++; if (regScr_W !== 4'd2) $display("FAIL b2b_rs2 got %h want 2", regScr_W);           else n_pass++;
    n_chk++; if (result_W !== r2)   $display("FAIL b2b_res2 got %h want %h", result_W, r2);     else n_pass++;
  endtask

  task automatic test_timeout();
    sync(); drive(1, 1, 1, 0, 1, 4'd6, $urandom(), $urandom()); mem_ack = 0;
    for (int k = 1; k <= TO; k++) begin
      sync(); mem_ack = 0; mem_rdata = $urandom();
      mid();
      n_chk++; if (mem_req !== 1'b1) $display("FAIL tmo_req k=%0d got %b want 1", k, mem_req); else n_pass++;
      n_chk++; if (bus_err !== 1'b0) $display("FAIL tmo_err_early k=%0d got %b want 0", k, bus_err); else n_pass++;
    end
    sync(); idle();
    mid();
    n_chk++; if (mem_req  !== 1'b0) $display("FAIL tmo_req_drop got %b want 0", mem_req);  else n_pass++;
    n_chk++; if (bus_err  !== 1'b1) $display("FAIL tmo_bus_err got %b want 1", bus_err);   else n_pass++;
    n_chk++; if (valid_W  !== 1'b1) $display("FAIL tmo_valid_W got %b want 1", valid_W);   else n_pass++;
    n_chk++; if (regw_W   !== 1'b0) $display("FAIL tmo_regw_W got %b want 0", regw_W);     else n_pass++;
    n_chk++; if (pcload_W !== 1'b1) $display("FAIL tmo_pcload_W got %b want 1", pcload_W); else n_pass++;
    n_chk++; if (result_W !== '0)   $display("FAIL tmo_result got %h want 0", result_W);   else n_pass++;
    repeat (5) sync();
    mid();
    n_chk++; if (bus_err !== 1'b1) $display("FAIL tmo_err_sticky got %b want 1", bus_err); else n_pass++;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL tmo_req_idle got %b want 0", mem_req);   else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    sync(); drive(1, 1, 1, 0, 0, 4'hA, 32'hA5A5A5A5, '0);
    sync(); drive(1, 0, 1, 0, 1, 4'hC, $urandom(), $urandom()); mem_ack = 0;
    repeat (2) sync();
    mid();
    n_chk++; if (mem_req !== 1'b1) $display("FAIL rstbusy_pre_req got %b want 1", mem_req); else n_pass++;
    #2 rst = 0; idle();
    #1;
    n_chk++; if (mem_req  !== 1'b0) $display("FAIL rstbusy_req got %b want 0", mem_req);       else n_pass++;
    n_chk++; if (valid_W  !== 1'b0) $display("FAIL rstbusy_valid_W got %b want 0", valid_W);   else n_pass++;
    n_chk++; if (regw_W   !== 1'b0) $display("FAIL rstbusy_regw_W got %b want 0", regw_W);     else n_pass++;
    n_chk++; if (pcload_W !== 1'b0) $display("FAIL rstbusy_pcload_W got %b want 0", pcload_W); else n_pass++;
    n_chk++; if (regScr_W !== 4'd0) $display("FAIL rstbusy_regScr_W got %h want 0", regScr_W); else n_pass++;
    n_chk++; if (result_W !== '0)   $display("FAIL rstbusy_result_W got %h want 0", result_W); else n_pass++;
    n_chk++; if (bus_err  !== 1'b0) $display("FAIL rstbusy_bus_err got %b want 0", bus_err);   else n_pass++;
    sync(); mid();
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rstbusy_req_held got %b want 0", mem_req);   else n_pass++;
    rst = 1;
    sync(); idle();
    mid();
    n_chk++; if (stall_M !== 1'b0) $display("FAIL rstbusy_idle_stall got %b want 0", stall_M); else n_pass++;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rstbusy_idle_req got %b want 0", mem_req);   else n_pass++;
  endtask

  task automatic test_random();
    ins_t prog[$];
    ins_t c, nop;
    int   idx = 0, k = 0, cyc = 0;
    logic err = 0;
    logic          exp_v = 0, exp_rw = 0, exp_pc = 0;
    logic [3:0]    exp_rs = '0;
    logic [DW-1:0] exp_res = '0;
    nop = '{default: '0};
    for (int i = 0; i < 60; i++) begin
      c = nop;
      case ($urandom_range(0, 3))
        0: ;
        1: begin c.v = 1; c.pc = 1'($urandom()); c.rw = 1'($urandom()); end
        2: begin c.v = 1; c.rm = 1; c.rw = 1'($urandom()); c.pc = 1'($urandom()); end
        default: begin c.v = 1; c.mw = 1; c.rm = 1'($urandom()); c.rw = 1'($urandom()); c.pc = 1'($urandom()); end
      endcase
      if (c.v) begin c.rs = 4'($urandom()); c.alu = $urandom(); c.addr = $urandom(); end
      c.lat = ($urandom_range(0, 4) == 0) ? 99 : $urandom_range(1, TO);
      prog.push_back(c);
    end
    sync(); idle(); mem_ack = 0; rst = 0;
    mid(); rst = 1;
    while (idx < prog.size() + 2 && cyc < 3000) begin
      logic          is_mem, ack, tmo;
      logic [DW-1:0] rd;
      c = (idx < prog.size()) ? prog[idx] : nop;
      sync();
      drive(c.v, c.pc, c.rw, c.mw, c.rm, c.rs, c.alu, c.addr);
      is_mem = c.v && (c.mw || c.rm);
      rd = $urandom(); mem_rdata = rd;
      ack = (is_mem && k >= 1) ? (k == c.lat) : 1'($urandom());
      mem_ack = ack;
      tmo = is_mem && (k == TO) && !ack;
      mid();
      n_chk++; if (mem_req !== (is_mem && k >= 1)) $display("FAIL rnd_req cyc=%0d got %b", cyc, mem_req); else n_pass++;
      n_chk++; if (bus_err !== err)    $display("FAIL rnd_bus_err cyc=%0d got %b want %b", cyc, bus_err, err);  else n_pass++;
      n_chk++; if (valid_W !== exp_v)  $display("FAIL rnd_valid_W cyc=%0d got %b want %b", cyc, valid_W, exp_v); else n_pass++;
      n_chk++; if (regw_W !== exp_rw)  $display("FAIL rnd_regw_W cyc=%0d got %b want %b", cyc, regw_W, exp_rw);  else n_pass++;
      n_chk++; if (pcload_W !== exp_pc) $display("FAIL rnd_pcload_W cyc=%0d got %b want %b", cyc, pcload_W, exp_pc); else n_pass++;
      if (exp_v) begin
        n_chk++; if (regScr_W !== exp_rs)  $display("FAIL rnd_regScr_W cyc=%0d got %h want %h", cyc, regScr_W, exp_rs);  else n_pass++;
        n_chk++; if (result_W !== exp_res) $display("FAIL rnd_result_W cyc=%0d got %h want %h", cyc, result_W, exp_res); else n_pass++;
      end
      if (!tmo) begin
        n_chk++; if (stall_M !== (is_mem && !(k >= 1 && ack))) $display("FAIL rnd_stall cyc=%0d got %b", cyc, stall_M); else n_pass++;
      end
      if (is_mem && k >= 1) begin
        n_chk++; if (mem_addr !== c.addr)  $display("FAIL rnd_addr cyc=%0d got %h want %h", cyc, mem_addr, c.addr);  else n_pass++;
        n_chk++; if (mem_wdata !== c.alu)  $display("FAIL rnd_wdata cyc=%0d got %h want %h", cyc, mem_wdata, c.alu); else n_pass++;
        n_chk++; if (mem_we !== c.mw)      $display("FAIL rnd_we cyc=%0d got %b want %b", cyc, mem_we, c.mw);        else n_pass++;
      end
      // Reference model: what the coming edge writes into MEM/WB.
      if (!is_mem) begin
        exp_v = c.v; exp_rw = c.v & c.rw; exp_pc = c.v & c.pc; exp_rs = c.rs; exp_res = c.alu;
        idx++;
      end else if (k == 0) begin
        exp_v = 0; exp_rw = 0; exp_pc = 0; k = 1;
      end else if (ack) begin
        exp_v = 1; exp_rw = c.rw & ~c.mw; exp_pc = c.pc; exp_rs = c.rs;
        exp_res = c.mw ? c.alu : rd;
        idx++; k = 0;
      end else if (k == TO) begin
        exp_v = 1; exp_rw = 0; exp_pc = c.pc; exp_rs = c.rs; exp_res = '0; err = 1;
        idx++; k = 0;
      end else begin
        exp_v = 0; exp_rw = 0; exp_pc = 0; k++;
      end
      cyc++;
    end
    n_chk++; if (cyc >= 3000) $display("FAIL rnd_budget idx=%0d want %0d", idx, prog.size() + 2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_at_timeout();
    test_idle_ack();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
